bn_var_stats: RTL and testbench

//  Streaming batch-norm statistics stage feeding the FP16 inverse-square-root unit.

---
 rtl/bn_var_stats.sv | 125 ++++++++++++
 tb/tb_bn_var_stats.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bn_var_stats.sv
// bn_var_stats: streaming FP16 mean / (variance + epsilon) over N-sample windows.
module bn_var_stats #(
  parameter int          DATA_WIDTH = 16,
  parameter int          N          = 16,
  parameter logic [15:0] INV_N      = 16'h2C00,
  parameter logic [15:0] EPSILON    = 16'h1400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mean_out,
  output logic [DATA_WIDTH-1:0] var_eps_out,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {ACC, CALC1, CALC2, OUT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_count;
  logic [15:0] r_sum, r_sumsq, r_mean, r_ex2;
  logic r_out_valid;
  logic w_acc, w_last;
  logic [15:0] w_sq, w_dif, w_d;
  // Round-to-nearest-even packer shared by the adder and multiplier; subnormals flush to zero.
  function automatic logic [15:0] pack(input logic s, input int e, input logic [10:0] m, input logic g, input logic st);
    logic [11:0] r;
    int x;
    r = {1'b0, m} + 12'(g & (st | m[0]));
    x = r[11] ? e + 1 : e;
    if (x <= 0) return {s, 15'h0};
    if (x >= 31) return {s, 5'h1f, 10'h0};
    return {s, x[4:0], r[11] ? r[10:1] : r[9:0]};
  endfunction
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic s, g, st;
    logic [21:0] p;
    logic [10:0] m;
    int e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0) return {s, 15'h0};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[21:11]; g = p[10]; st = |p[9:0]; e = e + 1;
    end else begin
      m = p[20:10]; g = p[9]; st = |p[8:0];
    end
    return pack(s, e, m, g, st);
  endfunction
  // Operands are aligned exactly in a wide field so rounding happens once.
  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [42:0] ma, mb, r, n;
    int d, p, e;
    if (x[14:10] == 5'h0 && y[14:10] == 5'h0) return {x[15] & y[15], 15'h0};
    if (y[14:10] == 5'h0 || x[14:10] == 5'h1f) return x;
    if (x[14:10] == 5'h0 || y[14:10] == 5'h1f) return y;
    {a, b} = (x[14:0] >= y[14:0]) ? {x, y} : {y, x};
    d = int'(a[14:10]) - int'(b[14:10]);
    ma = {2'b01, a[9:0], 31'h0};
    mb = {2'b01, b[9:0], 31'h0} >> d;
    r = (a[15] == b[15]) ? ma + mb : ma - mb;
    if (r == 43'h0) return 16'h0;
    p = 0;
    for (int i = 0; i < 43; i++) if (r[i]) p = i;
    e = int'(a[14:10]) + p - 41;
    n = r << (42 - p);
    return pack(a[15], e, n[42:32], n[31], |n[30:0]);
  endfunction
  assign in_ready  = (r_state == ACC);
  assign out_valid = r_out_valid;
  assign w_acc     = in_valid & in_ready;
  assign w_last    = (r_count == CW'(N - 1));
  assign w_sq      = fmul(in_data, in_data);
  assign w_dif     = fadd(r_ex2, fmul(r_mean, r_mean) ^ 16'h8000);
  assign w_d       = w_dif[15] ? 16'h0 : w_dif;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ACC;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACC:     w_next = (w_acc && w_last) ? CALC1 : ACC;
      CALC1:   w_next = CALC2;
      CALC2:   w_next = OUT;
      default: w_next = (r_out_valid && out_ready) ? ACC : OUT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_count     <= '0;
      r_sum       <= 16'h0;
      r_sumsq     <= 16'h0;
      r_mean      <= 16'h0;
      r_ex2       <= 16'h0;
      mean_out    <= 16'h0;
      var_eps_out <= 16'h0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ACC: if (w_acc) begin
          r_sum   <= fadd(r_sum, in_data);
          r_sumsq <= fadd(r_sumsq, w_sq);
          r_count <= w_last ? '0 : r_count + 1'b1;
        end
        CALC1: begin
          r_mean <= fmul(r_sum, INV_N);
          r_ex2  <= fmul(r_sumsq, INV_N);
        end
        CALC2: begin
          var_eps_out <= fadd(w_d, EPSILON);
          mean_out    <= r_mean;
          r_out_valid <= 1'b1;
        end
        default: if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
          r_sum       <= 16'h0;
          r_sumsq     <= 16'h0;
        end
      endcase
    end
endmodule

// File: tb/tb_bn_var_stats.sv
// tb_bn_var_stats: random and directed windows against a real-valued FP16 reference model.
module tb_bn_var_stats;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [15:0] in_data = 16'h0, mean_out, var_eps_out;
  int total = 0, bad = 0, n_acc = 0;
  logic [15:0] win[$];
  logic [15:0] hm, hv;
  always #5 clk = ~clk;
  bn_var_stats dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mean_out(mean_out), .var_eps_out(var_eps_out), .out_valid(out_valid), .out_ready(out_ready)
  );
  always @(posedge clk) if (in_valid && in_ready && !reset) n_acc++;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic real f2r(input logic [15:0] h);
    real m;
    int e;
    if (h[14:10] == 5'h0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction
  function automatic logic [15:0] r2f(input real r);
    real a, m;
    int e, mi;
    logic s;
    if (r == 0.0) return 16'h0;
    e = 0;
    s = (r < 0.0);
    a = s ? -r : r;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = a * 1024.0;
    mi = int'($floor(m));
    if (m - mi > 0.5 || (m - mi == 0.5 && mi % 2 == 1)) mi++;
    if (mi == 2048) begin mi = 1024; e++; end
    e = e + 15;
    if (e <= 0) return {s, 15'h0};
    if (e >= 31) return {s, 5'h1f, 10'h0};
    return {s, 5'(e), 10'(mi)};
  endfunction
  function automatic real rn(input real r);
    return f2r(r2f(r));
  endfunction
  task automatic model(output logic [15:0] em, output logic [15:0] ev);
    real s, q, mu, ex2, d, x;
    s = 0.0; q = 0.0;
    foreach (win[i]) begin
      x = f2r(win[i]);
      s = rn(s + x);
      q = rn(q + rn(x * x));
    end
    mu  = rn(s * f2r(16'h2C00));
    ex2 = rn(q * f2r(16'h2C00));
    d   = rn(ex2 - rn(mu * mu));
    if (d < 0.0) d = 0.0;
    em = r2f(mu);
    ev = r2f(rn(d + f2r(16'h1400)));
  endtask
  task automatic send(input logic [15:0] x);
    int t;
    in_data = x;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("ready_timeout", {15'h0, in_ready}, 16'h1);
    @(posedge clk); #1;
  endtask
  task automatic run_window(input int maxgap, input int bp, input string tag, output logic [15:0] om, output logic [15:0] ov);
    logic [15:0] em, ev;
    int a0, a1;
    model(em, ev);
    a0 = n_acc;
    foreach (win[i]) begin
      if (maxgap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      end
      send(win[i]);
    end
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {15'h0, out_valid}, 16'h0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, {15'h0, out_valid}, 16'h0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, {15'h0, out_valid}, 16'h1);
    chk({tag, "_mean"}, mean_out, em);
    chk({tag, "_var"}, var_eps_out, ev);
    chk({tag, "_accepts"}, 16'(n_acc - a0), 16'd16);
    om = mean_out;
    ov = var_eps_out;
    if (bp > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h4400;
      a1 = n_acc;
      repeat (bp) begin
        @(posedge clk); #1;
        chk({tag, "_bp_valid"}, {15'h0, out_valid}, 16'h1);
        chk({tag, "_bp_ready"}, {15'h0, in_ready}, 16'h0);
        chk({tag, "_bp_mean"}, mean_out, em);
        chk({tag, "_bp_var"}, var_eps_out, ev);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_bp_noconsume"}, 16'(n_acc - a1), 16'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_release_valid"}, {15'h0, out_valid}, 16'h0);
    chk({tag, "_release_ready"}, {15'h0, in_ready}, 16'h1);
    chk({tag, "_hold_mean"}, mean_out, em);
  endtask
  task automatic fill(input logic [15:0] a, input logic [15:0] b);
    win.delete();
    for (int i = 0; i < 16; i++) win.push_back(i % 2 == 0 ? a : b);
  endtask
  initial begin
    #12;
    chk("rst_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_ready", {15'h0, in_ready}, 16'h1);
    chk("rst_mean", mean_out, 16'h0);
    chk("rst_var", var_eps_out, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    fill(16'h3C00, 16'h3C00);
    run_window(0, 0, "ones", hm, hv);
    chk("ones_mean_k", hm, 16'h3C00);
    chk("ones_var_k", hv, 16'h1400);
    fill(16'h3C00, 16'hBC00);
    run_window(0, 0, "alt", hm, hv);
    chk("alt_mean_mag", {1'b0, hm[14:0]}, 16'h0);
    chk("alt_var_k", hv, 16'h3C01);
    fill(16'h4000, 16'h4000);
    run_window(3, 0, "gaps", hm, hv);
    chk("gaps_mean_k", hm, 16'h4000);
    chk("gaps_var_k", hv, 16'h1400);
    fill(16'h3C00, 16'h3C00);
    run_window(0, 5, "bp", hm, hv);
    for (int i = 0; i < 7; i++) send(16'h4000);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst2_valid", {15'h0, out_valid}, 16'h0);
    chk("rst2_ready", {15'h0, in_ready}, 16'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    fill(16'h3C00, 16'h3C00);
    run_window(0, 0, "postrst", hm, hv);
    chk("postrst_mean_k", hm, 16'h3C00);
    chk("postrst_var_k", hv, 16'h1400);
    run_window(1, 0, "two_a", hm, hv);
    fill(16'h4000, 16'h4000);
    run_window(0, 0, "two_b", hm, hv);
    chk("two_b_mean_k", hm, 16'h4000);
    chk("two_b_var_k", hv, 16'h1400);
    for (int w = 0; w < 8; w++) begin
      win.delete();
      for (int i = 0; i < 16; i++) win.push_back(r2f(real'(int'($urandom_range(32, 0)) - 16) / 4.0));
      run_window(2, int'($urandom_range(3, 0)), "rand", hm, hv);
      chk("rand_floor", {15'h0, f2r(hv) >= f2r(16'h1400)}, 16'h1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
